multi_xfer_seq: RTL and testbench
=================================

# multi_xfer_seq

Parametrised load/store-multiple sequencer for the pipelined RISC core. It replaces the fixed 8-register multiple-instruction controller and address generator pair with a single block. The block accepts an LM/SM request from decode and emits one register/address micro-op per cycle toward register-read. It adds descending mode, abort/flush, hold, and a final-address output that the current design lacks. It sits between instruction decode and the ID/RR pipeline register, and its `busy` output freezes fetch and decode.

## Interface
Parameters:
- `DATA_W`, 16: address and data width.
- `NREG`, 8: register-mask width, i.e. number of architectural registers.
- `IDX_W`, $clog2(NREG): register index width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe. Sampled only in IDLE with `hold`=0.
- `is_store`  in  1  1 = SM (store multiple), 0 = LM (load multiple). Latched at start.
- `dir`  in  1  0 = ascending (lowest index first, address +1 per op); 1 = descending (highest index first, address −1 per op). Latched at start.
- `mask`  in  NREG  register-select bits. Latched at start.
- `base_addr`  in  DATA_W  first address. Latched at start.
- `hold`  in  1  pipeline stall. Freezes all state and outputs.
- `abort`  in  1  flush from branch resolution. Takes priority over `hold` and `start`.
- `busy`  out  1  sequence in progress; used to stall the PC and decode.
- `uop_valid`  out  1  micro-op valid this cycle.
- `uop_store`  out  1  latched `is_store`.
- `uop_reg`  out  IDX_W  register index of the current micro-op.
- `uop_addr`  out  DATA_W  memory address of the current micro-op.
- `uop_last`  out  1  current micro-op is the final one.
- `done`  out  1  one-cycle pulse when the sequence completes.
- `final_addr`  out  DATA_W  address after the last op, for base writeback. Held until the next start.

## Operation
- States: IDLE, RUN, FIN.
- IDLE → RUN when `start` & !`hold` & !`abort` & `mask`≠0. On this transition, latch `mask`, `base_addr`, `dir` and `is_store`.
- IDLE → FIN when `start` & !`hold` & !`abort` & `mask`=0. No micro-ops are issued. `final_addr` = `base_addr`.
- In RUN, the current register is the lowest set bit of the remaining mask when `dir`=0, or the highest set bit when `dir`=1.
- Each RUN cycle with !`hold`:
  - clear the current register's bit in the remaining mask;
  - update the address by +1 (`dir`=0) or −1 (`dir`=1), modulo 2^DATA_W (wraps 0xFFFF↔0x0000);
  - `uop_last` = remaining-mask popcount == 1;
  - if last, go to FIN and set `final_addr` = updated address.
- FIN: `done`=1 for exactly one cycle, then IDLE. `hold` does not extend FIN.
- `abort` in any state: go to IDLE next cycle. No `done`, remaining mask cleared, `final_addr` unchanged.
- `start` while in RUN or FIN is ignored.
- Reset mid-sequence: same effect as abort, plus all outputs take their reset values.

## Timing
- Reset values: state IDLE; `busy`, `uop_valid`, `uop_store`, `uop_last`, `done` = 0; `uop_reg`, `uop_addr`, `final_addr` = 0.
- All outputs are registered or decoded from registered state only; there is no input→output combinational path.
- `busy`=1 and `uop_valid`=1 exactly while in RUN. The first micro-op appears in the cycle after `start` is accepted.
- Latency: N set bits produce N micro-op cycles (plus hold cycles), followed by one `done` cycle. `busy` drops in the same cycle `done` rises.
- `hold`=1 in RUN: the same micro-op is presented unchanged on the next cycle.
- A new `start` is accepted in the cycle after `done` at the earliest (IDLE).

## Structure
- Shared package `risc_pkg`: `DATA_W` default, state enum `mx_state_t` {IDLE, RUN, FIN}, and `dir` encoding constants `MX_ASC` = 0, `MX_DESC` = 1.
- Sub-module `prio_enc_n`, parametrised by `NREG`. Inputs: mask and direction. Outputs: index, `any`, and `one_left`. It is instantiated once in `multi_xfer_seq`.
- The rest is one sequential process (state, remaining mask, address, outputs) plus next-state logic.

## Test plan
- Ascending LM: mask=8'b1010_0101, base=0x0040, dir=0 → 4 micro-ops with reg 0,2,5,7 at addr 0x40,0x41,0x42,0x43; `uop_last` on the 4th op; `done` the next cycle; `final_addr`=0x0044.
- Descending SM: mask=8'b1000_0011, base=0x0010, dir=1 → reg 7,1,0 at addr 0x10,0x0F,0x0E; `uop_store`=1 throughout; `final_addr`=0x000D.
- Wrap-around: mask=8'h03, base=0xFFFF, dir=0 → addr 0xFFFF then 0x0000; `final_addr`=0x0001.
- Empty mask: start with mask=0 → `uop_valid` never asserts; `done` pulses in the cycle after start; `busy` stays 0.
- Hold and abort: hold for 2 cycles during the 2nd of 4 micro-ops → that op is repeated 3 cycles, then the sequence resumes. A second run with abort on the 3rd op → IDLE next cycle, no `done`, and a new start one cycle later is accepted.
- Reset and start-while-busy: `reset_n`=0 mid-RUN → all outputs 0 next cycle. `start` pulsed during RUN → ignored; the latched mask is unchanged.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the load/store-multiple sequencer
// Contents: DATA_W_DEFAULT (default address/data width), mx_state_t {IDLE, RUN, FIN},
// direction encodings MX_ASC / MX_DESC.
package risc_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mx_state_t;

    localparam logic MX_ASC  = 1'b0;
    localparam logic MX_DESC = 1'b1;

endpackage

// File: rtl/multi_xfer_seq_if.sv
// rtl/multi_xfer_seq_if.sv - decode-side request / micro-op bundle for multi_xfer_seq
// master: decode (drives start, is_store, dir, mask, base_addr, hold, abort; observes results)
// slave : sequencer (drives busy, uop_*, done, final_addr)
interface multi_xfer_seq_if #(
    parameter int DATA_W = risc_pkg::DATA_W_DEFAULT,
    parameter int NREG   = 8,
    parameter int IDX_W  = $clog2(NREG)
);
    logic              start;
    logic              is_store;
    logic              dir;
    logic [NREG-1:0]   mask;
    logic [DATA_W-1:0] base_addr;
    logic              hold;
    logic              abort;

    logic              busy;
    logic              uop_valid;
    logic              uop_store;
    logic [IDX_W-1:0]  uop_reg;
    logic [DATA_W-1:0] uop_addr;
    logic              uop_last;
    logic              done;
    logic [DATA_W-1:0] final_addr;

    modport master (
        output start, is_store, dir, mask, base_addr, hold, abort,
        input  busy, uop_valid, uop_store, uop_reg, uop_addr, uop_last, done, final_addr
    );

    modport slave (
        input  start, is_store, dir, mask, base_addr, hold, abort,
        output busy, uop_valid, uop_store, uop_reg, uop_addr, uop_last, done, final_addr
    );
endinterface

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - direction-selectable priority encoder over a register mask
// Ports: mask (in), dir (in, MX_ASC picks lowest set bit, MX_DESC highest),
// idx (out, selected index, 0 when mask empty), any (out, mask nonzero),
// one_left (out, exactly one bit set).
module prio_enc_n
    import risc_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int IDX_W = $clog2(NREG)
) (
    input  logic [NREG-1:0]  mask,
    input  logic             dir,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_left
);

    // Scan so that the winning bit is the last one to overwrite idx.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (dir == MX_DESC) begin
                if (mask[i]) idx = IDX_W'(i);
            end else begin
                if (mask[NREG-1-i]) idx = IDX_W'(NREG - 1 - i);
            end
        end
    end

    assign any      = |mask;
    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign one_left = any && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/multi_xfer_seq.sv
// rtl/multi_xfer_seq.sv - load/store-multiple sequencer, one register/address micro-op per cycle
// Ports: clk, reset_n (sync, active-low), bus (multi_xfer_seq_if.slave): request in
// (start, is_store, dir, mask, base_addr, hold, abort), micro-op out (busy, uop_valid,
// uop_store, uop_reg, uop_addr, uop_last), completion out (done, final_addr).
module multi_xfer_seq
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int NREG   = 8,
    parameter int IDX_W  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset_n,
    multi_xfer_seq_if.slave bus
);

    mx_state_t         state, state_n;
    logic [NREG-1:0]   rem,   rem_n;
    logic [DATA_W-1:0] addr,  addr_n;
    logic [DATA_W-1:0] fin,   fin_n;
    logic              store_q, store_n;
    logic              dir_q,   dir_n;

    logic [IDX_W-1:0]  cur_idx;
    logic              any_left;
    logic              one_left;

    prio_enc_n #(.NREG(NREG), .IDX_W(IDX_W)) u_enc (
        .mask     (rem),
        .dir      (dir_q),
        .idx      (cur_idx),
        .any      (any_left),
        .one_left (one_left)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rem     <= '0;
            addr    <= '0;
            fin     <= '0;
            store_q <= 1'b0;
            dir_q   <= MX_ASC;
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            addr    <= addr_n;
            fin     <= fin_n;
            store_q <= store_n;
            dir_q   <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        addr_n  = addr;
        fin_n   = fin;
        store_n = store_q;
        dir_n   = dir_q;

        unique case (state)
            IDLE: begin
                if (bus.start && !bus.hold && !bus.abort) begin
                    store_n = bus.is_store;
                    dir_n   = bus.dir;
                    if (bus.mask != '0) begin
                        rem_n   = bus.mask;
                        addr_n  = bus.base_addr;
                        state_n = RUN;
                    end else begin
                        fin_n   = bus.base_addr;
                        state_n = FIN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    rem_n   = '0;
                    state_n = IDLE;
                end else if (!bus.hold) begin
                    rem_n  = rem & ~(NREG'(1) << cur_idx);
                    addr_n = (dir_q == MX_DESC) ? addr - 1'b1 : addr + 1'b1;
                    // !any_left cannot occur in RUN; exiting keeps the FSM from sticking.
                    if (one_left || !any_left) begin
                        fin_n   = addr_n;
                        state_n = FIN;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                rem_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy       = (state == RUN);
    assign bus.uop_valid  = (state == RUN);
    assign bus.uop_store  = store_q;
    assign bus.uop_reg    = cur_idx;
    assign bus.uop_addr   = addr;
    assign bus.uop_last   = (state == RUN) && one_left;
    assign bus.done       = (state == FIN);
    assign bus.final_addr = fin;

endmodule

// File: tb/tb_multi_xfer_seq.sv
// tb/tb_multi_xfer_seq.sv - self-checking bench for multi_xfer_seq
module tb_multi_xfer_seq;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int IDX_W  = 3;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    multi_xfer_seq_if #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) bus ();

    multi_xfer_seq #(.DATA_W(DATA_W), .NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_final = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},      32'(bus.busy),      32'd0);
        chk({tag, ".uop_valid"}, 32'(bus.uop_valid), 32'd0);
        chk({tag, ".done"},      32'(bus.done),      32'd0);
    endtask

    // One request, checked against a list-of-ops model built from the mask.
    // hold_k/hold_len force a hold burst on op hold_k; abort_k aborts on that op;
    // reset_k asserts reset on that op; noise pulses start with junk fields during RUN.
    task automatic run_seq(input logic [NREG-1:0] m, input logic [DATA_W-1:0] b,
                           input logic d, input logic s, input int hold_pct,
                           input int hold_k, input int hold_len, input int abort_k,
                           input int reset_k, input bit noise);
        int regs[$];
        int n, k, held, budget;
        logic h;
        logic [DATA_W-1:0] ea;

        regs = {};
        for (int i = 0; i < NREG; i++) begin
            if (d == 1'b0 && m[i]) regs.push_back(i);
            if (d == 1'b1 && m[NREG-1-i]) regs.push_back(NREG - 1 - i);
        end
        n = regs.size();

        bus.start = 1'b1; bus.mask = m; bus.base_addr = b;
        bus.dir = d; bus.is_store = s; bus.hold = 1'b0; bus.abort = 1'b0;
        step();
        bus.start = 1'b0;
        bus.mask = NREG'($urandom); bus.base_addr = DATA_W'($urandom);
        bus.dir = ~d; bus.is_store = ~s;

        k = 0; held = 0; budget = 0;
        while (k < n) begin
            ea = DATA_W'(int'(b) + (d ? -k : k));
            chk("run.busy",      32'(bus.busy),      32'd1);
            chk("run.uop_valid", 32'(bus.uop_valid), 32'd1);
            chk("run.uop_reg",   32'(bus.uop_reg),   32'(regs[k]));
            chk("run.uop_addr",  32'(bus.uop_addr),  32'(ea));
            chk("run.uop_store", 32'(bus.uop_store), 32'(s));
            chk("run.uop_last",  32'(bus.uop_last),  32'(k == n - 1));
            chk("run.done",      32'(bus.done),      32'd0);
            if (k == reset_k) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
                exp_final = '0;
                chk("rst.busy",       32'(bus.busy),       32'd0);
                chk("rst.uop_valid",  32'(bus.uop_valid),  32'd0);
                chk("rst.uop_store",  32'(bus.uop_store),  32'd0);
                chk("rst.uop_reg",    32'(bus.uop_reg),    32'd0);
                chk("rst.uop_addr",   32'(bus.uop_addr),   32'd0);
                chk("rst.uop_last",   32'(bus.uop_last),   32'd0);
                chk("rst.done",       32'(bus.done),       32'd0);
                chk("rst.final_addr", 32'(bus.final_addr), 32'd0);
                return;
            end
            if (k == abort_k) begin
                bus.abort = 1'b1; bus.hold = 1'b1; bus.start = 1'b1;
                step();
                bus.abort = 1'b0; bus.hold = 1'b0; bus.start = 1'b0;
                chk_quiet("abort");
                chk("abort.final_addr", 32'(bus.final_addr), 32'(exp_final));
                return;
            end
            if (k == hold_k && held < hold_len) begin
                h = 1'b1;
                held++;
            end else begin
                h = ($urandom_range(99) < hold_pct);
            end
            bus.hold  = h;
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.mask  = NREG'($urandom);
            step();
            if (!h) k++;
            budget++;
            if (budget > 200) begin
                chk("run.timeout", 32'(budget), 32'd0);
                return;
            end
        end
        bus.hold = 1'b0; bus.start = 1'b0;

        exp_final = DATA_W'(int'(b) + (d ? -n : n));
        chk("fin.done",       32'(bus.done),       32'd1);
        chk("fin.busy",       32'(bus.busy),       32'd0);
        chk("fin.uop_valid",  32'(bus.uop_valid),  32'd0);
        chk("fin.final_addr", 32'(bus.final_addr), 32'(exp_final));
        bus.hold = 1'($urandom);
        step();
        bus.hold = 1'b0;
        chk_quiet("idle");
        chk("idle.final_addr", 32'(bus.final_addr), 32'(exp_final));
    endtask

    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.is_store = 1'b0; bus.dir = 1'b0;
        bus.mask = '0; bus.base_addr = '0; bus.hold = 1'b0; bus.abort = 1'b0;
        step();
        step();
        chk_quiet("reset");
        chk("reset.uop_reg",    32'(bus.uop_reg),    32'd0);
        chk("reset.uop_addr",   32'(bus.uop_addr),   32'd0);
        chk("reset.uop_last",   32'(bus.uop_last),   32'd0);
        chk("reset.uop_store",  32'(bus.uop_store),  32'd0);
        chk("reset.final_addr", 32'(bus.final_addr), 32'd0);
        reset_n = 1'b1;
        step();

        // start under hold in IDLE is not sampled
        bus.start = 1'b1; bus.hold = 1'b1; bus.mask = 8'hFF;
        step();
        bus.start = 1'b0; bus.hold = 1'b0;
        chk_quiet("hold_idle");

        // directed cases
        run_seq(8'b1010_0101, 16'h0040, 1'b0, 1'b0, 0, -1, 0, -1, -1, 1'b0);
        run_seq(8'b1000_0011, 16'h0010, 1'b1, 1'b1, 0, -1, 0, -1, -1, 1'b0);
        run_seq(8'h03,        16'hFFFF, 1'b0, 1'b0, 0, -1, 0, -1, -1, 1'b0);
        run_seq(8'h00,        16'h1234, 1'b0, 1'b1, 0, -1, 0, -1, -1, 1'b0);
        run_seq(8'b0110_1001, 16'h0200, 1'b0, 1'b0, 0,  1, 2, -1, -1, 1'b0);
        run_seq(8'b1111_0000, 16'h0300, 1'b1, 1'b1, 0, -1, 0,  2, -1, 1'b0);
        run_seq(8'b0000_1110, 16'h0001, 1'b1, 1'b0, 0, -1, 0, -1, -1, 1'b1);
        run_seq(8'b1100_1100, 16'h0500, 1'b0, 1'b1, 0, -1, 0, -1,  1, 1'b0);
        step();

        // randomized requests with random holds and start noise
        for (int t = 0; t < 40; t++) begin
            logic [NREG-1:0] rm;
            rm = ($urandom_range(9) == 0) ? '0 : NREG'($urandom);
            run_seq(rm, DATA_W'($urandom), 1'($urandom), 1'($urandom), 30,
                    -1, 0, ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1,
                    -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
